iq_dac_ramp: RTL and testbench

Parametrised I/Q DAC output stage between the burst controller's two's-complement I/Q samples and the two offset-binary DAC pin buses. Replaces the fixed "+31" output registers with a width-generic converter that adds a symmetric clamp, a linear power ramp at burst edges, and a txchain_en window that leads and lags the RF samples by programmable cycle counts. Samples are delayed internally so the RF chain is enabled before the first sample reaches the DACs.

---
 rtl/iq_dac_ramp.sv | 173 +++++++++++++++++
 tb/tb_iq_dac_ramp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/iq_dac_ramp.sv
// I/Q DAC output stage: symmetric clamp, sample delay line, linear burst-edge power ramp,
// offset-binary conversion and a txchain_en window that leads and lags the RF samples.

module iq_dac_ramp_lane #(
  parameter int WIDTH     = 6,
  parameter int RAMP_LOG2 = 2,
  parameter int TXEN_LEAD = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     sample_i,
  input  logic                 v_d_i,
  input  logic [RAMP_LOG2:0]   lvl_i,
  output logic [WIDTH-1:0]     dac_o
);
  localparam int MID = 2**(WIDTH-1) - 1;
  localparam int PW  = WIDTH + RAMP_LOG2 + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(1) << (WIDTH-1);

  logic [WIDTH-1:0]                  clamped;
  logic [TXEN_LEAD-1:0][WIDTH-1:0]   dly_q;
  logic [WIDTH-1:0]                  s_d;
  logic [WIDTH-1:0]                  hold_q;
  logic [WIDTH-1:0]                  src;
  logic signed [PW-1:0]              prod;
  logic signed [PW-1:0]              scaled;
  logic [WIDTH-1:0]                  dac_d;
  logic [WIDTH-1:0]                  dac_q;

  // -2^(W-1) has no positive twin; fold it onto -M so full scale is symmetric
  assign clamped = (sample_i == MOST_NEG) ? MOST_NEG + 1'b1 : sample_i;
  assign s_d     = dly_q[TXEN_LEAD-1];
  assign src     = v_d_i ? s_d : hold_q;
  assign prod    = PW'($signed(src)) * PW'($signed({1'b0, lvl_i}));
  assign scaled  = prod >>> RAMP_LOG2;
  assign dac_d   = WIDTH'(scaled + PW'(MID));
  assign dac_o   = dac_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      dly_q  <= '0;
      hold_q <= '0;
      dac_q  <= WIDTH'(MID);
    end else begin
      dly_q[0] <= clamped;
      for (int k = 1; k < TXEN_LEAD; k++) dly_q[k] <= dly_q[k-1];
      if (v_d_i) hold_q <= s_d;
      dac_q <= dac_d;
    end
  end
endmodule

module iq_dac_ramp #(
  parameter int WIDTH     = 6,
  parameter int RAMP_LOG2 = 2,
  parameter int TXEN_LEAD = 2,
  parameter int TXEN_LAG  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iq_valid,
  input  logic [WIDTH-1:0] inphase_in,
  input  logic [WIDTH-1:0] quadrature_in,
  output logic [WIDTH-1:0] dac_i,
  output logic [WIDTH-1:0] dac_q,
  output logic             txchain_en,
  output logic             ramping,
  output logic             burst_done
);
  localparam int NUM_LANES = 2;
  localparam int N         = 2**RAMP_LOG2;
  localparam int LW        = RAMP_LOG2 + 1;
  localparam int CW        = $clog2(TXEN_LAG + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_LAG} state_t;

  logic [NUM_LANES-1:0][WIDTH-1:0] smp_in;
  logic [NUM_LANES-1:0][WIDTH-1:0] dac_out;
  logic [TXEN_LEAD-1:0]            vld_q;
  logic                            v_d;
  logic                            any_dly;
  logic [LW-1:0]                   lvl_q, lvl_d;
  logic                            ramping_q;
  state_t                          state_q;
  logic [CW-1:0]                   lag_cnt_q;
  logic                            txen_q;
  logic                            done_q;

  assign smp_in  = {quadrature_in, inphase_in};
  assign v_d     = vld_q[TXEN_LEAD-1];
  assign any_dly = |vld_q;

  always_comb begin
    lvl_d = lvl_q;
    if (v_d && lvl_q != LW'(N))
      lvl_d = lvl_q + 1'b1;
    else if (!v_d && lvl_q != '0)
      lvl_d = lvl_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q     <= '0;
      lvl_q     <= '0;
      ramping_q <= 1'b0;
    end else begin
      vld_q[0] <= iq_valid;
      for (int k = 1; k < TXEN_LEAD; k++) vld_q[k] <= vld_q[k-1];
      lvl_q     <= lvl_d;
      ramping_q <= (lvl_d != '0) && (lvl_d != LW'(N));
    end
  end

  // Scaling uses lvl_d so the ramp step lands on the same edge as the sample it scales
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    iq_dac_ramp_lane #(
      .WIDTH     (WIDTH),
      .RAMP_LOG2 (RAMP_LOG2),
      .TXEN_LEAD (TXEN_LEAD)
    ) u_lane (
      .clock    (clock),
      .reset    (reset),
      .sample_i (smp_in[g]),
      .v_d_i    (v_d),
      .lvl_i    (lvl_d),
      .dac_o    (dac_out[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lag_cnt_q <= '0;
      txen_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (iq_valid) begin
            state_q <= S_ACTIVE;
            txen_q  <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (lvl_d == '0 && !any_dly) begin
            state_q   <= S_LAG;
            lag_cnt_q <= CW'(TXEN_LAG);
          end
        end
        S_LAG: begin
          // New traffic wins over expiry so the RF chain never blinks between bursts
          if (iq_valid || any_dly) begin
            state_q <= S_ACTIVE;
          end else if (lag_cnt_q == '0) begin
            state_q <= S_IDLE;
            txen_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            lag_cnt_q <= lag_cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dac_i      = dac_out[0];
  assign dac_q      = dac_out[1];
  assign txchain_en = txen_q;
  assign ramping    = ramping_q;
  assign burst_done = done_q;
endmodule

// File: tb/tb_iq_dac_ramp.sv
// Bench for iq_dac_ramp: vector table, directed corner sequences, random traffic vs a timeline model.

module tb_iq_dac_ramp;
  localparam int WIDTH = 6;
  localparam int M     = 31;
  localparam int N     = 4;
  localparam int LEAD  = 2;
  localparam int LAGC  = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             iq_valid = 1'b0;
  logic [WIDTH-1:0] inphase_in = '0;
  logic [WIDTH-1:0] quadrature_in = '0;
  logic [WIDTH-1:0] dac_i, dac_q;
  logic             txchain_en, ramping, burst_done;

  iq_dac_ramp #(.WIDTH(WIDTH), .RAMP_LOG2(2), .TXEN_LEAD(LEAD), .TXEN_LAG(LAGC)) dut (
    .clock         (clock),
    .reset         (reset),
    .iq_valid      (iq_valid),
    .inphase_in    (inphase_in),
    .quadrature_in (quadrature_in),
    .dac_i         (dac_i),
    .dac_q         (dac_q),
    .txchain_en    (txchain_en),
    .ramping       (ramping),
    .burst_done    (burst_done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: the delay line is a queue, the ramp level is an integer,
  // and txchain_en is derived from the time elapsed since the last cycle with any activity.
  bit mv[$];
  int mi[$], mq[$];
  int mL, mhi, mhq, mcyc, mlast;
  bit have_last, prev_tx, model_ok;
  int exp_di, exp_dq;
  bit exp_tx, exp_rp, exp_dn;

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int clampv(input int x);
    return (x == -32) ? -31 : x;
  endfunction

  task automatic model_step(input bit r, input bit v, input int i, input int q);
    bit vd, anyd;
    int id, qd, lnx;
    if (r) begin
      mv.delete(); mi.delete(); mq.delete();
      for (int k = 0; k < LEAD; k++) begin mv.push_back(1'b0); mi.push_back(0); mq.push_back(0); end
      mL = 0; mhi = 0; mhq = 0; mcyc = 0; have_last = 0; prev_tx = 0;
      exp_di = M; exp_dq = M; exp_tx = 0; exp_rp = 0; exp_dn = 0;
      model_ok = 1;
    end else begin
      vd = mv[0]; id = mi[0]; qd = mq[0];
      anyd = 0;
      foreach (mv[k]) if (mv[k]) anyd = 1;
      if (vd) lnx = (mL < N) ? mL + 1 : mL;
      else    lnx = (mL > 0) ? mL - 1 : 0;
      if (vd) begin mhi = id; mhq = qd; end
      exp_di = M + floor_div(mhi * lnx, N);
      exp_dq = M + floor_div(mhq * lnx, N);
      exp_rp = (lnx > 0) && (lnx < N);
      mL = lnx;
      if (v || lnx > 0 || anyd) begin have_last = 1; mlast = mcyc; end
      exp_tx = have_last && (mcyc - mlast <= LAGC + 1);
      exp_dn = prev_tx && !exp_tx;
      prev_tx = exp_tx;
      void'(mv.pop_front()); void'(mi.pop_front()); void'(mq.pop_front());
      mv.push_back(v); mi.push_back(clampv(i)); mq.push_back(clampv(q));
      mcyc++;
    end
  endtask

  task automatic next_cycle();
    @(negedge clock);
    if (model_ok) begin
      chk("model dac_i", int'(dac_i), exp_di);
      chk("model dac_q", int'(dac_q), exp_dq);
      chk("model txchain_en", int'(txchain_en), int'(exp_tx));
      chk("model ramping", int'(ramping), int'(exp_rp));
      chk("model burst_done", int'(burst_done), int'(exp_dn));
    end
  endtask

  task automatic drive(input bit r, input bit v, input int i, input int q);
    reset = r; iq_valid = v;
    inphase_in = WIDTH'(i); quadrature_in = WIDTH'(q);
    model_step(r, v, i, q);
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(63)) - 32;
  endfunction

  typedef struct {
    bit v; int i; int q;
    int di; int dq; bit tx; bit rp; bit dn;
  } vec_t;

  vec_t tbl[20];
  int   tdi[20];
  int   ci[7], cq[7];
  bit   burst_on;

  initial begin
    model_ok = 0;
    tdi = '{31,31,31,38,45,52,59,59,59,59,59,52,45,38,31,31,31,31,31,31};
    for (int k = 0; k < 20; k++) begin
      tbl[k].v  = (k < 8);
      tbl[k].i  = (k < 8) ? 28 : 0;
      tbl[k].q  = (k < 8) ? -28 : 0;
      tbl[k].di = tdi[k];
      tbl[k].dq = 62 - tdi[k];
      tbl[k].tx = (k >= 1 && k <= 17);
      tbl[k].rp = (k >= 3 && k <= 5) || (k >= 11 && k <= 13);
      tbl[k].dn = (k == 18);
    end

    // reset held three cycles with random inputs
    for (int r = 0; r < 3; r++) begin
      next_cycle();
      if (r > 0) begin
        chk("rst dac_i", int'(dac_i), M);
        chk("rst dac_q", int'(dac_q), M);
        chk("rst txchain_en", int'(txchain_en), 0);
        chk("rst ramping", int'(ramping), 0);
        chk("rst burst_done", int'(burst_done), 0);
      end
      drive(1'b1, 1'($urandom_range(1)), rnd_s(), rnd_s());
    end

    // constant burst vector table
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      chk("tbl dac_i", int'(dac_i), tbl[k].di);
      chk("tbl dac_q", int'(dac_q), tbl[k].dq);
      chk("tbl txchain_en", int'(txchain_en), int'(tbl[k].tx));
      chk("tbl ramping", int'(ramping), int'(tbl[k].rp));
      chk("tbl burst_done", int'(burst_done), int'(tbl[k].dn));
      drive(1'b0, tbl[k].v, tbl[k].i, tbl[k].q);
    end

    // clamp and rounding
    ci = '{-5, 0, 0, -32, -32, 31, 31};
    cq = '{0, 0, 0, 31, 31, -32, -32};
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      if (k == 3) chk("round dac_i", int'(dac_i), 29);
      if (k == 6 || k == 7) begin
        chk("clamp neg dac_i", int'(dac_i), 0);
        chk("clamp pos dac_q", int'(dac_q), 62);
      end
      if (k == 8 || k == 9) begin
        chk("clamp pos dac_i", int'(dac_i), 62);
        chk("clamp neg dac_q", int'(dac_q), 0);
      end
      if (k <= 6) drive(1'b0, 1'b1, ci[k], cq[k]);
      else        drive(1'b0, 1'b0, 0, 0);
    end

    // second burst starting one cycle after LAG entry
    for (int k = 0; k < 30; k++) begin
      next_cycle();
      if (k >= 1 && k <= 24) chk("reburst txchain_en", int'(txchain_en), 1);
      if (k <= 24) chk("reburst no burst_done", int'(burst_done), 0);
      if (k == 13) chk("reburst idle dac_i", int'(dac_i), 31);
      if (k == 14) chk("reburst ramp 1/4 dac_i", int'(dac_i), 36);
      if (k == 25) begin
        chk("reburst end burst_done", int'(burst_done), 1);
        chk("reburst end txchain_en", int'(txchain_en), 0);
      end
      drive(1'b0, (k < 4) || (k >= 11 && k < 15), 20, -20);
    end

    // one-cycle gap at full scale
    for (int k = 0; k < 24; k++) begin
      next_cycle();
      if (k == 8)  begin chk("gap full dac_i", int'(dac_i), 43); chk("gap full dac_q", int'(dac_q), 23); end
      if (k == 9)  begin chk("gap 3/4 dac_i", int'(dac_i), 40); chk("gap 3/4 dac_q", int'(dac_q), 25); end
      if (k == 10) begin chk("gap new dac_i", int'(dac_i), 15); chk("gap new dac_q", int'(dac_q), 47); end
      if (k >= 1 && k <= 12) chk("gap txchain_en", int'(txchain_en), 1);
      drive(1'b0, (k <= 5) || (k >= 7 && k <= 10), (k <= 5) ? 12 : -16, (k <= 5) ? -8 : 16);
    end

    // reset at full scale
    for (int k = 0; k < 16; k++) begin
      next_cycle();
      if (k == 6) chk("midrst pre dac_i", int'(dac_i), 41);
      if (k == 8) begin
        chk("midrst dac_i", int'(dac_i), M);
        chk("midrst dac_q", int'(dac_q), M);
      end
      if (k >= 8) begin
        chk("midrst txchain_en", int'(txchain_en), 0);
        chk("midrst burst_done", int'(burst_done), 0);
      end
      drive(k == 7, k <= 7, 10, -10);
    end

    // random bursty traffic
    burst_on = 0;
    for (int k = 0; k < 3000; k++) begin
      next_cycle();
      if ($urandom_range(99) < 8) burst_on = !burst_on;
      drive($urandom_range(399) == 0, burst_on && ($urandom_range(9) != 0), rnd_s(), rnd_s());
    end
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
